ssram_bus_arbiter: RTL

Two-master controller for the ssram_256 register bank: arbitrates between requester A (host interface) and requester B (internal core), and runs one bank access at a time. Decodes an 8-bit register address into the bank's one-hot 16-bit row/column selects, sequences we/re strobes, owns the shared tri-state data bus and returns read data. Sits between the host/core logic and the bank; it is the only driver of row, column, we and re.

---
 rtl/ssram_bus_arbiter_pkg.sv | 18 +
 rtl/ssram_bus_arbiter_if.sv | 36 +++
 rtl/ssram_bus_arbiter_dec.sv | 13 +
 rtl/ssram_bus_arbiter.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/ssram_bus_arbiter_pkg.sv
// Shared types and address-field constants for the ssram_256 bank controller.
package ssram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned ROW_MSB = 7;
    localparam int unsigned ROW_LSB = 4;
    localparam int unsigned COL_MSB = 3;
    localparam int unsigned COL_LSB = 0;
    localparam int unsigned SEL_W   = 16;

endpackage

// File: rtl/ssram_bus_arbiter_if.sv
// Requester-side handshake bundle: requester A (host) and requester B (core).
interface ssram_bus_arbiter_if
    import ssram_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 16
);
    logic              req_a;
    logic              wr_a;
    logic [ADDR_W-1:0] addr_a;
    logic [WIDTH-1:0]  wdata_a;
    logic [WIDTH-1:0]  rdata_a;
    logic              ack_a;
    logic              err_a;

    logic              req_b;
    logic              wr_b;
    logic [ADDR_W-1:0] addr_b;
    logic [WIDTH-1:0]  wdata_b;
    logic [WIDTH-1:0]  rdata_b;
    logic              ack_b;
    logic              err_b;

    modport master (
        output req_a, wr_a, addr_a, wdata_a,
        input  rdata_a, ack_a, err_a,
        output req_b, wr_b, addr_b, wdata_b,
        input  rdata_b, ack_b, err_b
    );

    modport slave (
        input  req_a, wr_a, addr_a, wdata_a,
        output rdata_a, ack_a, err_a,
        input  req_b, wr_b, addr_b, wdata_b,
        output rdata_b, ack_b, err_b
    );
endinterface

// File: rtl/ssram_bus_arbiter_dec.sv
// 4-bit to 16-bit one-hot decoder used for the bank row and column selects.
module onehot_dec_4to16
    import ssram_ctrl_pkg::*;
(
    input  logic [3:0]       i_sel,
    output logic [SEL_W-1:0] o_onehot
);
    // Exactly one output bit set, at the position given by i_sel.
    always_comb begin
        o_onehot        = '0;
        o_onehot[i_sel] = 1'b1;
    end
endmodule

// File: rtl/ssram_bus_arbiter.sv
// Two-requester round-robin controller for the ssram_256 register bank.
// Runs one access at a time through IDLE -> SETUP -> STROBE -> DONE.
module ssram_bus_arbiter
    import ssram_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 256
) (
    input  logic               clk,
    input  logic               rst,
    ssram_bus_arbiter_if.slave bus,
    output logic [SEL_W-1:0]   row,
    output logic [SEL_W-1:0]   column,
    output logic               we,
    output logic               re,
    inout  wire  [WIDTH-1:0]   data,
    output logic               busy,
    output logic               grant
);
    state_t            r_state;
    state_t            w_next;
    logic              r_last;
    logic              r_grant;
    logic              r_wr;
    logic              r_bad;
    logic              r_busy;
    logic              r_we;
    logic              r_re;
    logic              r_drv;
    logic              r_ack_a;
    logic              r_ack_b;
    logic              r_err_a;
    logic              r_err_b;
    logic [ADDR_W-1:0] r_addr;
    logic [WIDTH-1:0]  r_wdata;
    logic [WIDTH-1:0]  r_rdata_a;
    logic [WIDTH-1:0]  r_rdata_b;
    logic [SEL_W-1:0]  r_row;
    logic [SEL_W-1:0]  r_col;

    logic              w_start;
    logic              w_pick_b;
    logic              w_win_wr;
    logic              w_win_bad;
    logic              w_cur_owner;
    logic              w_cur_wr;
    logic              w_cur_bad;
    logic              w_sel;
    logic [ADDR_W-1:0] w_win_addr;
    logic [ADDR_W-1:0] w_cur_addr;
    logic [WIDTH-1:0]  w_win_wdata;
    logic [SEL_W-1:0]  w_row_dec;
    logic [SEL_W-1:0]  w_col_dec;

    // Winner selection: a lone request wins; on contention the side not granted last wins.
    always_comb begin
        w_pick_b    = bus.req_b & (~bus.req_a | ~r_last);
        w_start     = (r_state == IDLE) & (bus.req_a | bus.req_b);
        w_win_wr    = w_pick_b ? bus.wr_b    : bus.wr_a;
        w_win_addr  = w_pick_b ? bus.addr_b  : bus.addr_a;
        w_win_wdata = w_pick_b ? bus.wdata_b : bus.wdata_a;
        w_win_bad   = ({{(32-ADDR_W){1'b0}}, w_win_addr} >= DEPTH);
    end

    // Next-state sequencing; rejected addresses skip straight to DONE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_next = w_win_bad ? DONE : SETUP;
            SETUP:   w_next = STROBE;
            STROBE:  w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    // Outputs are registered one edge ahead, so in IDLE the winner's fields
    // stand in for the latched transaction fields.
    assign w_cur_addr  = (r_state == IDLE) ? w_win_addr : r_addr;
    assign w_cur_wr    = (r_state == IDLE) ? w_win_wr   : r_wr;
    assign w_cur_owner = (r_state == IDLE) ? w_pick_b   : r_grant;
    assign w_cur_bad   = (r_state == IDLE) ? w_win_bad  : r_bad;
    assign w_sel       = (w_next == SETUP) | (w_next == STROBE);

    onehot_dec_4to16 u_row_dec (
        .i_sel    (w_cur_addr[ROW_MSB:ROW_LSB]),
        .o_onehot (w_row_dec)
    );

    onehot_dec_4to16 u_col_dec (
        .i_sel    (w_cur_addr[COL_MSB:COL_LSB]),
        .o_onehot (w_col_dec)
    );

    // Transaction state, bank strobes/selects, handshake pulses and read capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_last    <= 1'b1;
            r_grant   <= 1'b0;
            r_wr      <= 1'b0;
            r_bad     <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_busy    <= 1'b0;
            r_row     <= '0;
            r_col     <= '0;
            r_we      <= 1'b0;
            r_re      <= 1'b0;
            r_drv     <= 1'b0;
            r_ack_a   <= 1'b0;
            r_ack_b   <= 1'b0;
            r_err_a   <= 1'b0;
            r_err_b   <= 1'b0;
            r_rdata_a <= '0;
            r_rdata_b <= '0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_grant <= w_pick_b;
                r_last  <= w_pick_b;
                r_wr    <= w_win_wr;
                r_addr  <= w_win_addr;
                r_wdata <= w_win_wdata;
                r_bad   <= w_win_bad;
            end
            r_busy  <= (w_next != IDLE);
            r_row   <= w_sel ? w_row_dec : '0;
            r_col   <= w_sel ? w_col_dec : '0;
            r_we    <= (w_next == STROBE) & r_wr;
            r_re    <= (w_next == STROBE) & ~r_wr;
            r_drv   <= w_sel & w_cur_wr;
            r_ack_a <= (w_next == DONE) & ~w_cur_owner;
            r_ack_b <= (w_next == DONE) &  w_cur_owner;
            r_err_a <= (w_next == DONE) & ~w_cur_owner & w_cur_bad;
            r_err_b <= (w_next == DONE) &  w_cur_owner & w_cur_bad;
            if ((r_state == STROBE) && !r_wr) begin
                if (r_grant) r_rdata_b <= data;
                else         r_rdata_a <= data;
            end
        end
    end

    assign data        = r_drv ? r_wdata : 'z;
    assign row         = r_row;
    assign column      = r_col;
    assign we          = r_we;
    assign re          = r_re;
    assign busy        = r_busy;
    assign grant       = r_grant;
    assign bus.rdata_a = r_rdata_a;
    assign bus.rdata_b = r_rdata_b;
    assign bus.ack_a   = r_ack_a;
    assign bus.ack_b   = r_ack_b;
    assign bus.err_a   = r_err_a;
    assign bus.err_b   = r_err_b;

endmodule
